// File: rtl/ser_add_seq.sv
// ser_add_seq: feeds two W-bit operands LSB-first into a bit-serial adder and
// reassembles the parallel sum with carry-out and signed-overflow flags.
`default_nettype none

module ser_add_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_op_a,
  input  logic [W-1:0] i_op_b,
  output logic         o_res_valid,
  input  logic         i_res_ready,
  output logic [W-1:0] o_sum,
  output logic         o_cout,
  output logic         o_ovf,
  output logic         o_busy,
  output logic         o_add_a,
  output logic         o_add_b,
  output logic         o_add_clr,
  input  logic         i_add_q,
  input  logic         i_add_v
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   sh_a;
  logic [W-1:0]   sh_b;
  logic [W-1:0]   res;
  logic           cout;
  logic           cmsb;
  logic           res_vld;
  logic           rdy;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_add_a   = 1'b0;
    o_add_b   = 1'b0;
    o_add_clr = 1'b0;
    case (state)
      IDLE:  if (i_valid && rdy) state_nxt = CLR;
      CLR: begin
        o_add_clr = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        o_add_a = sh_a[0];
        o_add_b = sh_b[0];
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE:  if (res_vld && i_res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      sh_a    <= '0;
      sh_b    <= '0;
      res     <= '0;
      cout    <= 1'b0;
      cmsb    <= 1'b0;
      res_vld <= 1'b0;
      rdy     <= 1'b0;
    end else begin
      // Registered ready keeps i_valid off any combinational path to o_ready.
      rdy <= (state_nxt == IDLE);
      case (state)
        IDLE: begin
          if (i_valid && rdy) begin
            sh_a <= i_op_a;
            sh_b <= i_op_b;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          res  <= {i_add_q, res[W-1:1]};
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          cnt  <= cnt + 1'b1;
          // Adder carry state here is the carry into the MSB.
          if (cnt == LAST) cmsb <= i_add_v;
        end
        DONE: begin
          if (!res_vld) begin
            cout    <= i_add_v;
            res_vld <= 1'b1;
          end else if (i_res_ready) begin
            res_vld <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready     = rdy;
  assign o_res_valid = res_vld;
  assign o_sum       = res;
  assign o_cout      = cout;
  assign o_ovf       = cmsb ^ cout;
  assign o_busy      = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ser_add_seq.sv
// Directed testbench for ser_add_seq with a behavioural bit-serial adder.
`default_nettype none

module tb_ser_add_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [W-1:0] i_op_a = '0;
  logic [W-1:0] i_op_b = '0;
  logic         o_res_valid;
  logic         i_res_ready = 1'b1;
  logic [W-1:0] o_sum;
  logic         o_cout;
  logic         o_ovf;
  logic         o_busy;
  logic         o_add_a;
  logic         o_add_b;
  logic         o_add_clr;
  logic         i_add_q;
  logic         i_add_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Serial adder: q = a^b^c, o_v holds the carry, clr zeroes it.
  logic c = 1'b0;
  assign i_add_q = o_add_a ^ o_add_b ^ c;
  assign i_add_v = c;
  always @(posedge clk) begin
    if (o_add_clr) c <= 1'b0;
    else           c <= (o_add_a & o_add_b) | (o_add_a & c) | (o_add_b & c);
  end

  ser_add_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .o_res_valid(o_res_valid),
    .i_res_ready(i_res_ready), .o_sum(o_sum), .o_cout(o_cout), .o_ovf(o_ovf),
    .o_busy(o_busy), .o_add_a(o_add_a), .o_add_b(o_add_b),
    .o_add_clr(o_add_clr), .i_add_q(i_add_q), .i_add_v(i_add_v)
  );

  // Issues one pair and waits for the result; the operand bus is scrambled
  // after accept so any sampling while busy corrupts the sum.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] sum, output logic co, output logic ov,
                       output int lat, output int clrs, output bit ok);
    ok = 1'b0; lat = 0; clrs = 0; sum = '0; co = 1'b0; ov = 1'b0;
    i_op_a = a; i_op_b = b; i_valid = 1'b1;
    for (int i = 0; i < 100 && !o_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!o_ready) begin
      i_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_op_a = ~a; i_op_b = ~b;
    for (int n = 1; n <= 200; n++) begin
      if (o_res_valid) begin
        lat = n;
        ok = 1'b1;
        break;
      end
      clrs += int'(o_add_clr);
      @(posedge clk); #1;
    end
    if (!ok) return;
    sum = o_sum; co = o_cout; ov = o_ovf;
    if (i_res_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; i_valid = 1'b0; i_res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_ready, o_res_valid, o_busy, o_cout, o_ovf} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got rdy=%b vld=%b busy=%b co=%b ov=%b want all 0",
               o_ready, o_res_valid, o_busy, o_cout, o_ovf);
    end
    checks++;
    if ({o_sum, o_add_a, o_add_b, o_add_clr} !== '0) begin
      errors++;
      $display("FAIL reset_data got sum=%h a=%b b=%b clr=%b want 0",
               o_sum, o_add_a, o_add_b, o_add_clr);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", o_ready);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] s; logic co, ov; int lat, clrs; bit ok;
    do_op(32'd5, 32'd3, s, co, ov, lat, clrs, ok);
    checks++;
    if (!ok || s !== 32'd8 || co !== 1'b0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL basic_5p3 got ok=%0d sum=%h co=%b ov=%b want sum=8 co=0 ov=0",
               ok, s, co, ov);
    end
    checks++;
    if (lat !== W + 3) begin
      errors++;
      $display("FAIL basic_latency got %0d want %0d", lat, W + 3);
    end
    checks++;
    if (clrs !== 1) begin
      errors++;
      $display("FAIL basic_clr_cycles got %0d want 1", clrs);
    end
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle_after got rdy=%b busy=%b want 1/0", o_ready, o_busy);
    end
  endtask

  task automatic test_carry_ovf();
    logic [W-1:0] va [3] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [W-1:0] vb [3] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
    logic [W-1:0] vs [3] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
    logic         vc [3] = '{1'b1, 1'b0, 1'b1};
    logic         vo [3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] s; logic co, ov; int lat, clrs; bit ok;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], s, co, ov, lat, clrs, ok);
      checks++;
      if (!ok || s !== vs[i] || co !== vc[i] || ov !== vo[i]) begin
        errors++;
        $display("FAIL carry_vec%0d got ok=%0d sum=%h co=%b ov=%b want sum=%h co=%b ov=%b",
                 i, ok, s, co, ov, vs[i], vc[i], vo[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] s; logic co, ov; int lat, clrs; bit ok;
    i_res_ready = 1'b0;
    do_op(32'h1234_5678, 32'h1111_1111, s, co, ov, lat, clrs, ok);
    checks++;
    if (!ok || s !== 32'h2345_6789 || co !== 1'b0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL bp_result got ok=%0d sum=%h co=%b ov=%b want 23456789/0/0",
               ok, s, co, ov);
    end
    i_op_a = 32'hDEAD_BEEF; i_op_b = 32'hCAFE_F00D; i_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (o_res_valid !== 1'b1 || o_ready !== 1'b0 || o_sum !== 32'h2345_6789 ||
          o_cout !== 1'b0 || o_ovf !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got vld=%b rdy=%b sum=%h co=%b ov=%b want 1/0/23456789/0/0",
                 i, o_res_valid, o_ready, o_sum, o_cout, o_ovf);
      end
    end
    i_valid = 1'b0;
    i_res_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_res_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got busy=%b rdy=%b vld=%b want 0/1/0",
               o_busy, o_ready, o_res_valid);
    end
    do_op(32'hAAAA_AAAA, 32'h5555_5555, s, co, ov, lat, clrs, ok);
    checks++;
    if (!ok || s !== 32'hFFFF_FFFF || co !== 1'b0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL bp_next got ok=%0d sum=%h co=%b ov=%b want FFFFFFFF/0/0",
               ok, s, co, ov);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] s; logic co, ov; int lat, clrs; bit ok; bit seen;
    i_op_a = 32'h0000_1234; i_op_b = 32'h0000_4321; i_valid = 1'b1;
    for (int i = 0; i < 100 && !o_ready; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy got busy=%b rdy=%b want 1/0", o_busy, o_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checks++;
    if ({o_ready, o_res_valid, o_busy, o_cout, o_ovf, o_add_a, o_add_b, o_add_clr} !== 8'b0 ||
        o_sum !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got rdy=%b vld=%b busy=%b sum=%h co=%b ov=%b add=%b%b%b want 0",
               o_ready, o_res_valid, o_busy, o_sum, o_cout, o_ovf, o_add_a, o_add_b, o_add_clr);
    end
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (o_res_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_result got valid_seen=%b want 0", seen);
    end
    do_op(32'd2, 32'd2, s, co, ov, lat, clrs, ok);
    checks++;
    if (!ok || s !== 32'd4 || co !== 1'b0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL mid_after_2p2 got ok=%0d sum=%h co=%b ov=%b want 4/0/0",
               ok, s, co, ov);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_ovf();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
